// File: rtl/ras_ckpt_stack.sv
// Return-address stack on a circular buffer with checkpoint slots
// that let a mispredicted path roll the stack back to a saved state.
module ras_ckpt_stack #(
    parameter  int DEPTH   = 4,
    parameter  int ADDR_W  = 32,
    parameter  int NR_CKPT = 2,
    localparam int CW      = (NR_CKPT > 1) ? $clog2(NR_CKPT) : 1,
    localparam int PW      = $clog2(DEPTH),
    localparam int NW      = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic              pop_i,
    output logic              top_valid_o,
    output logic [ADDR_W-1:0] top_addr_o,
    output logic [NW-1:0]     count_o,
    input  logic              ckpt_i,
    output logic              ckpt_ready_o,
    output logic [CW-1:0]     ckpt_id_o,
    input  logic              release_i,
    input  logic [CW-1:0]     release_id_i,
    input  logic              restore_i,
    input  logic [CW-1:0]     restore_id_i
);

    logic [ADDR_W-1:0]  mem [DEPTH];
    logic [PW-1:0]      tos;
    logic [NW-1:0]      cnt;
    logic [NR_CKPT-1:0] busy;

    logic [PW-1:0]      sv_tos [NR_CKPT];
    logic [NW-1:0]      sv_cnt [NR_CKPT];
    logic [ADDR_W-1:0]  sv_top [NR_CKPT];

    logic [PW-1:0]      tos_nx;
    logic [NW-1:0]      cnt_nx;
    logic               wr_en;
    logic [PW-1:0]      wr_idx;
    logic [ADDR_W-1:0]  wr_data;
    logic               rid_ok;
    logic               lid_ok;
    logic               rest_ok;
    logic               alloc;

    assign top_valid_o = (cnt != '0);
    assign top_addr_o  = mem[tos];
    assign count_o     = cnt;

    assign rid_ok  = int'(restore_id_i) < NR_CKPT;
    assign lid_ok  = int'(release_id_i) < NR_CKPT;
    assign rest_ok = restore_i && rid_ok && busy[restore_id_i];
    assign alloc   = ckpt_i && ckpt_ready_o;

    // Lowest free slot wins; the loop walks downward so the last hit is lowest.
    always_comb begin
        ckpt_ready_o = 1'b0;
        ckpt_id_o    = '0;
        for (int i = NR_CKPT - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                ckpt_ready_o = 1'b1;
                ckpt_id_o    = CW'(i);
            end
        end
    end

    always_comb begin
        tos_nx  = tos;
        cnt_nx  = cnt;
        wr_en   = 1'b0;
        wr_idx  = tos;
        wr_data = push_addr_i;
        if (flush_i) begin
            tos_nx = '0;
            cnt_nx = '0;
        end else if (rest_ok) begin
            tos_nx  = sv_tos[restore_id_i];
            cnt_nx  = sv_cnt[restore_id_i];
            wr_en   = 1'b1;
            wr_idx  = sv_tos[restore_id_i];
            wr_data = sv_top[restore_id_i];
        end else if (push_i && pop_i && cnt != '0) begin
            wr_en = 1'b1;
        end else if (push_i) begin
            tos_nx = tos + 1'b1;
            wr_en  = 1'b1;
            wr_idx = tos + 1'b1;
            if (cnt != NW'(DEPTH)) begin
                cnt_nx = cnt + 1'b1;
            end
        end else if (pop_i && cnt != '0) begin
            tos_nx = tos - 1'b1;
            cnt_nx = cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tos  <= '0;
            cnt  <= '0;
            busy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            for (int i = 0; i < NR_CKPT; i++) begin
                sv_tos[i] <= '0;
                sv_cnt[i] <= '0;
                sv_top[i] <= '0;
            end
        end else begin
            tos <= tos_nx;
            cnt <= cnt_nx;
            if (wr_en) begin
                mem[wr_idx] <= wr_data;
            end
            if (flush_i) begin
                busy <= '0;
            end else begin
                if (release_i && lid_ok) begin
                    busy[release_id_i] <= 1'b0;
                end
                // Allocation is written last so it overrides a same-slot release.
                if (alloc) begin
                    busy[ckpt_id_o]   <= 1'b1;
                    sv_tos[ckpt_id_o] <= tos;
                    sv_cnt[ckpt_id_o] <= cnt;
                    sv_top[ckpt_id_o] <= mem[tos];
                end
            end
        end
    end

endmodule

// File: tb/tb_ras_ckpt_stack.sv
// Bench for ras_ckpt_stack: directed vector table, random run against
// a reference model, and an asynchronous reset sequence.
module tb_ras_ckpt_stack;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        push;
    logic [31:0] addr;
    logic        pop;
    logic        top_valid;
    logic [31:0] top_addr;
    logic [2:0]  count;
    logic        ckpt;
    logic        ckpt_ready;
    logic [0:0]  ckpt_id;
    logic        rel;
    logic [0:0]  rel_id;
    logic        restore;
    logic [0:0]  rest_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ras_ckpt_stack #(.DEPTH(4), .ADDR_W(32), .NR_CKPT(2)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .push_i(push), .push_addr_i(addr), .pop_i(pop),
        .top_valid_o(top_valid), .top_addr_o(top_addr), .count_o(count),
        .ckpt_i(ckpt), .ckpt_ready_o(ckpt_ready), .ckpt_id_o(ckpt_id),
        .release_i(rel), .release_id_i(rel_id),
        .restore_i(restore), .restore_id_i(rest_id)
    );

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(bit fl, bit pu, bit po, bit ck, bit rl, bit rlid,
                         bit rs, bit rsid, logic [31:0] a);
        flush = fl; push = pu; pop = po; ckpt = ck;
        rel = rl; rel_id = rlid; restore = rs; rest_id = rsid; addr = a;
    endtask

    typedef struct {
        bit fl, pu, po, ck, rl, rlid, rs, rsid;
        logic [31:0] a;
        int cnt;
        logic [31:0] top;
        bit chk_top;
        bit rdy;
        bit id;
    } vec_t;

    function automatic vec_t v(bit fl, bit pu, bit po, bit ck, bit rl, bit rlid,
                               bit rs, bit rsid, logic [31:0] a, int c,
                               logic [31:0] t, bit ct, bit rdy, bit id);
        vec_t r;
        r.fl = fl; r.pu = pu; r.po = po; r.ck = ck; r.rl = rl; r.rlid = rlid;
        r.rs = rs; r.rsid = rsid; r.a = a; r.cnt = c; r.top = t;
        r.chk_top = ct; r.rdy = rdy; r.id = id;
        return r;
    endfunction

    // Reference model: spec-level stack with explicit slot records.
    logic [31:0] mm [4];
    int          mt, mc;
    bit          mb [2];
    int          st [2], sc [2];
    logic [31:0] sa [2];

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mm[i] = 0;
        mt = 0; mc = 0;
        for (int i = 0; i < 2; i++) begin
            mb[i] = 0; st[i] = 0; sc[i] = 0; sa[i] = 0;
        end
    endtask

    function automatic int free_slot();
        for (int i = 0; i < 2; i++) if (!mb[i]) return i;
        return -1;
    endfunction

    task automatic model_step(bit fl, bit pu, bit po, bit ck, bit rl, int rlid,
                              bit rs, int rsid, logic [31:0] a);
        int  fid;
        bit  rok;
        fid = free_slot();
        rok = rs && mb[rsid];
        if (fl) begin
            mt = 0; mc = 0; mb[0] = 0; mb[1] = 0;
            return;
        end
        if (rl) mb[rlid] = 0;
        if (ck && fid >= 0) begin
            st[fid] = mt; sc[fid] = mc; sa[fid] = mm[mt]; mb[fid] = 1;
        end
        if (rok) begin
            mt = st[rsid]; mc = sc[rsid]; mm[mt] = sa[rsid];
        end else if (pu && po && mc > 0) begin
            mm[mt] = a;
        end else if (pu) begin
            mt = (mt + 1) % 4; mm[mt] = a;
            if (mc < 4) mc++;
        end else if (po && mc > 0) begin
            mt = (mt + 3) % 4; mc--;
        end
    endtask

    vec_t tbl [$];

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #12;
        check("rst_count", 32'(count), 0);
        check("rst_valid", 32'(top_valid), 0);
        check("rst_top", top_addr, 0);
        check("rst_ready", 32'(ckpt_ready), 1);
        check("rst_id", 32'(ckpt_id), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        //        fl pu po ck rl ri rs si addr     cnt top   ct rdy id
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 'h100, 1, 'h100, 1, 1, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 'h200, 2, 'h200, 1, 1, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 'h300, 3, 'h300, 1, 1, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 'h400, 4, 'h400, 1, 1, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 'h500, 4, 'h500, 1, 1, 0));
        tbl.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 0, 3, 'h400, 1, 1, 0));
        tbl.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 0, 2, 'h300, 1, 1, 0));
        tbl.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 'h200, 1, 1, 0));
        tbl.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 1, 1, 0, 0, 0, 0, 0, 'hA0, 1, 'hA0, 1, 1, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 'h10, 1, 'h10, 1, 1, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 'h20, 2, 'h20, 1, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 'h20, 1, 1, 1));
        tbl.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 'h10, 1, 1, 1));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 'h99, 2, 'h99, 1, 1, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 'h20, 1, 1, 1));
        tbl.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 'h10, 1, 1, 1));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 'h10, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 'h10, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 'h10, 1, 1, 1));
        tbl.push_back(v(0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 'h10, 1, 0, 0));
        tbl.push_back(v(1, 1, 0, 0, 0, 0, 1, 0, 'h55, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 1, 1, 'h77, 1, 'h77, 1, 1, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].fl, tbl[i].pu, tbl[i].po, tbl[i].ck, tbl[i].rl,
                  tbl[i].rlid, tbl[i].rs, tbl[i].rsid, tbl[i].a);
            @(posedge clk); #1;
            check($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].cnt));
            check($sformatf("vec%0d_valid", i), 32'(top_valid),
                  32'(tbl[i].cnt != 0));
            check($sformatf("vec%0d_ready", i), 32'(ckpt_ready), 32'(tbl[i].rdy));
            if (tbl[i].chk_top)
                check($sformatf("vec%0d_top", i), top_addr, tbl[i].top);
            if (tbl[i].rdy)
                check($sformatf("vec%0d_id", i), 32'(ckpt_id), 32'(tbl[i].id));
        end

        // Random traffic against the model, starting from a fresh reset.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #3;
        rst = 1'b0;
        model_reset();
        for (int n = 0; n < 600; n++) begin
            bit fl, pu, po, ck, rl, rlid, rs, rsid;
            logic [31:0] a;
            fl   = ($urandom_range(0, 29) == 0);
            pu   = ($urandom_range(0, 1) == 1);
            po   = ($urandom_range(0, 2) == 0);
            ck   = ($urandom_range(0, 3) == 0);
            rl   = ($urandom_range(0, 4) == 0);
            rlid = 1'($urandom_range(0, 1));
            rs   = ($urandom_range(0, 5) == 0);
            rsid = 1'($urandom_range(0, 1));
            a    = $urandom;
            drive(fl, pu, po, ck, rl, rlid, rs, rsid, a);
            model_step(fl, pu, po, ck, rl, int'(rlid), rs, int'(rsid), a);
            @(posedge clk); #1;
            check($sformatf("rnd%0d_count", n), 32'(count), 32'(mc));
            check($sformatf("rnd%0d_valid", n), 32'(top_valid), 32'(mc != 0));
            check($sformatf("rnd%0d_top", n), top_addr, mm[mt]);
            check($sformatf("rnd%0d_ready", n), 32'(ckpt_ready),
                  32'(free_slot() >= 0));
            if (free_slot() >= 0)
                check($sformatf("rnd%0d_id", n), 32'(ckpt_id), 32'(free_slot()));
        end

        // Asynchronous reset between edges with three entries held.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        for (int i = 1; i <= 3; i++) begin
            drive(0, 1, 0, 1, 0, 0, 0, 0, 32'(i * 'h1000));
            @(posedge clk); #1;
        end
        drive(0, 1, 0, 0, 0, 0, 0, 0, 'hBEEF);
        check("pre_arst_count", 32'(count), 3);
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", 32'(count), 0);
        check("arst_valid", 32'(top_valid), 0);
        check("arst_top", top_addr, 0);
        check("arst_ready", 32'(ckpt_ready), 1);
        check("arst_id", 32'(ckpt_id), 0);
        @(posedge clk); #1;
        check("arst_hold_count", 32'(count), 0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        check("post_arst_count", 32'(count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
